// File: rtl/noc_xbar_rr.sv
// noc_xbar_rr -- NUM_PORTS x NUM_PORTS wormhole crossbar with per-output
// round-robin arbitration, head-to-tail packet locking and one registered
// output stage.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_data/in_dest/in_tail -> in_ready   per-input flit channel
//   out_valid/out_data/out_tail <- out_ready       per-output registered channel
//   err_route                sticky per-input bad-route flag
//   flit_cnt, drop_cnt       statistics (only with NOC_XBAR_STATS_EN defined)
//
// Optional feature macro: NOC_XBAR_STATS_EN.
module noc_xbar_rr #(
  parameter  int NUM_PORTS = 5,
  parameter  int DATA_W    = 16,
  localparam int SEL_W     = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS-1:0]          in_valid,
  input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
  input  logic [NUM_PORTS*SEL_W-1:0]    in_dest,
  input  logic [NUM_PORTS-1:0]          in_tail,
  output logic [NUM_PORTS-1:0]          in_ready,
  output logic [NUM_PORTS-1:0]          out_valid,
  output logic [NUM_PORTS*DATA_W-1:0]   out_data,
  output logic [NUM_PORTS-1:0]          out_tail,
  input  logic [NUM_PORTS-1:0]          out_ready,
`ifdef NOC_XBAR_STATS_EN
  output logic [NUM_PORTS*32-1:0]       flit_cnt,
  output logic [31:0]                   drop_cnt,
`endif
  output logic [NUM_PORTS-1:0]          err_route
);

  typedef enum logic {IDLE, LOCKED} arb_st_e;

  logic [NUM_PORTS-1:0]                 in_pkt_q, bad_q, err_q;
  logic [NUM_PORTS-1:0][SEL_W-1:0]      route_q;
  logic [NUM_PORTS-1:0][SEL_W-1:0]      dest_eff;
  logic [NUM_PORTS-1:0]                 bad_eff, drop;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  req;   // [out][in]
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  gnt;   // [out][in], accepted this cycle

  // ---------------- per-input route tracking ----------------
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    logic [SEL_W-1:0] d;
    logic             head, bad_head;
    assign d        = in_dest[i*SEL_W +: SEL_W];
    assign head     = ~in_pkt_q[i];
    assign bad_head = (32'(d) == i) || (32'(d) >= NUM_PORTS);
    // Body/tail flits follow the route (and verdict) latched from the head.
    assign dest_eff[i] = head ? d : route_q[i];
    assign bad_eff[i]  = head ? bad_head : bad_q[i];
    // Bad-route packets are swallowed unconditionally so the input drains.
    assign drop[i]     = in_valid[i] & bad_eff[i] & ~rst;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        in_pkt_q[i] <= 1'b0;
        bad_q[i]    <= 1'b0;
        route_q[i]  <= '0;
        err_q[i]    <= 1'b0;
      end else begin
        if (in_valid[i] && in_ready[i]) begin
          in_pkt_q[i] <= ~in_tail[i];
          if (head) begin
            route_q[i] <= d;
            bad_q[i]   <= bad_head;
          end
        end
        if (drop[i] && head) err_q[i] <= 1'b1;
      end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_req
      assign req[o][i] = in_valid[i] & ~bad_eff[i] & (dest_eff[i] == SEL_W'(o));
    end
  end

  assign err_route = err_q;

  // ---------------- per-output arbiter + output register ----------------
  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
    arb_st_e           st_q;
    logic [SEL_W-1:0]  owner_q, rr_q, sel, rr_nxt;
    logic              hit, load, acc, sel_tail, vld_q, tail_q;
    logic [DATA_W-1:0] data_q;

    always_comb begin
      int j;
      sel = owner_q;
      hit = 1'b0;
      j   = 0;
      if (st_q == LOCKED) begin
        hit = req[o][owner_q];
      end else begin
        for (int k = 0; k < NUM_PORTS; k++) begin
          j = int'(rr_q) + k;
          if (j >= NUM_PORTS) j = j - NUM_PORTS;
          if (!hit && req[o][j]) begin
            hit = 1'b1;
            sel = SEL_W'(j);
          end
        end
      end
    end

    assign load     = ~vld_q | out_ready[o];
    assign acc      = hit & load & ~rst;
    assign sel_tail = in_tail[sel];
    assign rr_nxt   = (sel == SEL_W'(NUM_PORTS-1)) ? '0 : sel + 1'b1;
    assign gnt[o]   = acc ? (NUM_PORTS'(1) << sel) : '0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q    <= IDLE;
        owner_q <= '0;
        rr_q    <= '0;
        vld_q   <= 1'b0;
        tail_q  <= 1'b0;
        data_q  <= '0;
      end else begin
        if (acc) begin
          vld_q  <= 1'b1;
          data_q <= in_data[sel*DATA_W +: DATA_W];
          tail_q <= sel_tail;
        end else if (out_ready[o]) begin
          vld_q  <= 1'b0;
        end
        if (acc) begin
          case (st_q)
            IDLE:
              if (!sel_tail) begin
                st_q    <= LOCKED;
                owner_q <= sel;
              end else begin
                rr_q    <= rr_nxt;
              end
            LOCKED:
              if (sel_tail) begin
                st_q <= IDLE;
                rr_q <= rr_nxt;
              end
            default: st_q <= IDLE;
          endcase
        end
      end
    end

    assign out_valid[o]                  = vld_q;
    assign out_tail[o]                   = tail_q;
    assign out_data[o*DATA_W +: DATA_W]  = data_q;

`ifdef NOC_XBAR_STATS_EN
    logic [31:0] fcnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                          fcnt_q <= '0;
      else if (vld_q && out_ready[o])   fcnt_q <= fcnt_q + 32'd1;
    end
    assign flit_cnt[o*32 +: 32] = fcnt_q;
`endif
  end

  // An input has a single route, so at most one output grants it.
  always_comb begin
    in_ready = drop;
    for (int o = 0; o < NUM_PORTS; o++)
      in_ready = in_ready | gnt[o];
  end

`ifdef NOC_XBAR_STATS_EN
  logic [31:0] drop_cnt_q;
  logic [32:0] drop_sum;
  always_comb begin
    drop_sum = {1'b0, drop_cnt_q};
    for (int i = 0; i < NUM_PORTS; i++)
      if (drop[i]) drop_sum = drop_sum + 33'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_sum[32] ? '1 : drop_sum[31:0];
  end
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_noc_xbar_rr.sv
module tb_noc_xbar_rr;
  localparam int N  = 5;
  localparam int DW = 16;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      in_valid, in_tail, in_ready, out_valid, out_tail, out_ready, err_route;
  logic [N*DW-1:0]   in_data, out_data;
  logic [N*SW-1:0]   in_dest;
`ifdef NOC_XBAR_STATS_EN
  logic [N*32-1:0]   flit_cnt;
  logic [31:0]       drop_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  noc_xbar_rr #(.NUM_PORTS(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_dest(in_dest), .in_tail(in_tail),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tail(out_tail), .out_ready(out_ready),
`ifdef NOC_XBAR_STATS_EN
    .flit_cnt(flit_cnt), .drop_cnt(drop_cnt),
`endif
    .err_route(err_route)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drv(input int p, input logic v, input logic [DW-1:0] d,
                     input logic [SW-1:0] dst, input logic t);
    in_valid[p]          = v;
    in_data[p*DW +: DW]  = d;
    in_dest[p*SW +: SW]  = dst;
    in_tail[p]           = t;
  endtask

  task automatic clr();
    in_valid = '0; in_data = '0; in_dest = '0; in_tail = '0;
  endtask

  function automatic logic [DW-1:0] od(input int p);
    return out_data[p*DW +: DW];
  endfunction

  int seq [5] = '{1, 2, 3, 4, 1};

  initial begin
    rst = 1'b1; out_ready = '1; clr();
    // reset state, with inputs active to show in_ready stays low
    for (int p = 0; p < N; p++) drv(p, 1'b1, 16'h1234, 3'd1, 1'b1);
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tail", out_tail, 0);
    chk("rst_err", err_route, 0);
    clr(); rst = 1'b0;

    // single flit 1 -> 0, then rr_ptr[0]==2 shows as input 2 beating input 1
    drv(1, 1, 16'hA5A5, 3'd0, 1); #1;
    chk("t1_ready", in_ready, 5'b00010);
    tick();
    chk("t1_vld", out_valid, 5'b00001);
    chk("t1_data", od(0), 16'hA5A5);
    chk("t1_tail", out_tail, 5'b00001);
    drv(1, 1, 16'h1111, 3'd0, 1); drv(2, 1, 16'h2222, 3'd0, 1); #1;
    chk("rr2_ready", in_ready, 5'b00100);
    tick();
    chk("rr2_data", od(0), 16'h2222);
    drv(2, 0, 0, 0, 0); #1;
    chk("rr1_ready", in_ready, 5'b00010);
    tick();
    chk("rr1_data", od(0), 16'h1111);
    clr(); tick();
    chk("drain_vld", out_valid, 0);

    // round robin after reset: 1,2,3,4,1
    rst = 1'b1; tick(); rst = 1'b0;
    for (int p = 1; p < 5; p++) drv(p, 1, 16'(16'h0100 * p), 3'd0, 1);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("rr_ready%0d", c), in_ready, 64'(1 << seq[c]));
      tick();
      chk($sformatf("rr_data%0d", c), od(0), 64'(16'h0100 * seq[c]));
    end
    clr(); tick();

    // wormhole lock on out 3 with a backpressure stall mid-packet
    drv(2, 1, 16'h2000, 3'd3, 0); drv(4, 1, 16'h4000, 3'd3, 1); #1;
    chk("wh_ready0", in_ready, 5'b00100);
    tick();
    chk("wh_data0", od(3), 16'h2000);
    drv(2, 1, 16'h2001, 3'd0, 0); #1;
    chk("wh_ready1", in_ready, 5'b00100);
    tick();
    chk("wh_data1", od(3), 16'h2001);
    drv(2, 1, 16'h2002, 3'd0, 0); out_ready[3] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall_ready%0d", c), in_ready, 0);
      tick();
      chk($sformatf("stall_data%0d", c), od(3), 16'h2001);
      chk($sformatf("stall_vld%0d", c), out_valid[3], 1);
    end
    out_ready[3] = 1'b1; #1;
    chk("wh_ready2", in_ready, 5'b00100);
    tick();
    chk("wh_data2", od(3), 16'h2002);
    drv(2, 1, 16'h2003, 3'd0, 1); #1;
    chk("wh_ready3", in_ready, 5'b00100);
    tick();
    chk("wh_data3", od(3), 16'h2003);
    chk("wh_tail3", out_tail[3], 1);
    drv(2, 0, 0, 0, 0); #1;
    chk("wh_ready4", in_ready, 5'b10000);
    tick();
    chk("wh_data4", od(3), 16'h4000);
    clr(); tick();

    // bad route: input 0 to itself, two flits dropped
    drv(0, 1, 16'hDEAD, 3'd0, 0); #1;
    chk("bad_ready0", in_ready, 5'b00001);
    tick();
    chk("bad_vld0", out_valid, 0);
    chk("bad_err0", err_route, 5'b00001);
    drv(0, 1, 16'hBEEF, 3'd3, 1); #1;
    chk("bad_ready1", in_ready, 5'b00001);
    tick();
    chk("bad_vld1", out_valid, 0);
`ifdef NOC_XBAR_STATS_EN
    chk("drop_cnt", drop_cnt, 2);
`endif
    drv(0, 1, 16'h0C0C, 3'd2, 1); drv(1, 1, 16'h7777, 3'd7, 1); #1;
    chk("bad_ready2", in_ready, 5'b00011);
    tick();
    chk("bad_vld2", out_valid, 5'b00100);
    chk("bad_data2", od(2), 16'h0C0C);
    chk("bad_err2", err_route, 5'b00011);
    clr(); tick();

    // reset mid-packet: locks and in_pkt must clear
    drv(3, 1, 16'h3000, 3'd1, 0); #1;
    chk("mp_ready0", in_ready, 5'b01000);
    tick();
    chk("mp_data0", od(1), 16'h3000);
    drv(3, 1, 16'h3001, 3'd0, 0); rst = 1'b1; #1;
    chk("mp_rst_ready", in_ready, 0);
    chk("mp_rst_vld", out_valid, 0);
    chk("mp_rst_err", err_route, 0);
    tick(); rst = 1'b0;
    clr();
    drv(2, 1, 16'h2222, 3'd1, 1); drv(4, 1, 16'h4444, 3'd1, 1); drv(3, 1, 16'h3333, 3'd2, 1); #1;
    chk("mp_ready1", in_ready, 5'b01100);
    tick();
    chk("mp_vld1", out_valid, 5'b00110);
    chk("mp_data1", od(1), 16'h2222);
    chk("mp_data2", od(2), 16'h3333);
    clr(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
